// File: rtl/spu_env_pkg.sv
// Shared constants and encodings for the SPU ADSR envelope generator.
// Optional feature macro: SPU_ENV_EXP_MODE_EN (exponential attack/sustain/release modes).
package spu_env_pkg;

  localparam int unsigned LVL_W    = 15;
  localparam int unsigned ADR_W    = 7;
  localparam int unsigned DAT_W    = 14;
  localparam int unsigned STEP_LIN = 32;

  localparam logic [14:0] LEVEL_MAX = 15'h7FFF;
  localparam logic [14:0] ATK_KNEE  = 15'h6000;

  typedef enum logic [2:0] {
    PH_OFF     = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } env_phase_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_READ = 2'd1,
    SEQ_ACC  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/spu_env_step.sv
// Combinational envelope step: rate index, stepped level and next phase for one voice.
// SPU_ENV_EXP_MODE_EN enables the exponential attack/sustain/release mode bits.
module spu_env_step
  import spu_env_pkg::*;
#(
  parameter int unsigned STEP = STEP_LIN
) (
  input  logic [2:0]  phase,
  input  logic        apply,
  input  logic [14:0] level,
  input  logic        atk_exp,
  input  logic [6:0]  atk_rate,
  input  logic [3:0]  dec_shift,
  input  logic [3:0]  sus_level,
  input  logic        sus_exp,
  input  logic        sus_dec,
  input  logic [6:0]  sus_rate,
  input  logic        rel_exp,
  input  logic [4:0]  rel_shift,
  output logic [6:0]  rate_idx,
  output logic [14:0] level_next,
  output logic [2:0]  phase_next
);

  localparam logic [14:0] STEP_V = 15'(STEP);

  logic [14:0] inc_lvl, lin_lvl, exp_lvl;
  logic [7:0]  atk_idx, rel_idx;
  logic [15:0] thr;
  logic        atk_adj, sus_exp_on, rel_exp_on;

`ifdef SPU_ENV_EXP_MODE_EN
  assign atk_adj    = atk_exp && (level > ATK_KNEE);
  assign sus_exp_on = sus_exp;
  assign rel_exp_on = rel_exp;
`else
  logic unused_modes;
  assign unused_modes = atk_exp ^ sus_exp ^ rel_exp;
  assign atk_adj      = 1'b0;
  assign sus_exp_on   = 1'b0;
  assign rel_exp_on   = 1'b0;
`endif

  assign inc_lvl = (level > LEVEL_MAX - STEP_V) ? LEVEL_MAX : level + STEP_V;
  assign lin_lvl = (level < STEP_V) ? '0 : level - STEP_V;
  // (level>>7)+1 only exceeds level when level is 0, so that is the only floor case
  assign exp_lvl = (level == '0) ? '0 : level - ((level >> 7) + 15'd1);
  assign thr     = {11'd0, {1'b0, sus_level} + 5'd1} << 11;
  assign atk_idx = {1'b0, atk_rate} + (atk_adj ? 8'd8 : 8'd0);
  assign rel_idx = {1'b0, rel_shift, 2'b00};

  always_comb begin
    rate_idx   = '0;
    level_next = level;
    phase_next = phase;
    case (env_phase_t'(phase))
      PH_ATTACK: begin
        rate_idx = atk_idx[7] ? 7'h7F : atk_idx[6:0];
        if (apply) level_next = inc_lvl;
        if (level_next == LEVEL_MAX) phase_next = PH_DECAY;
      end
      PH_DECAY: begin
        rate_idx = {1'b0, dec_shift, 2'b00};
        if (apply) level_next = exp_lvl;
        if ({1'b0, level_next} <= thr) phase_next = PH_SUSTAIN;
      end
      PH_SUSTAIN: begin
        rate_idx = sus_rate;
        if (apply) level_next = !sus_dec ? inc_lvl : (sus_exp_on ? exp_lvl : lin_lvl);
      end
      PH_RELEASE: begin
        rate_idx = rel_idx[7] ? 7'h7F : rel_idx[6:0];
        if (apply) level_next = rel_exp_on ? exp_lvl : lin_lvl;
        if (level_next == '0) phase_next = PH_OFF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/spu_adsr_envelope.sv
// Single-voice SPU ADSR envelope: tick sequencer, rate accumulator and rate-ROM handshake.
// Define SPU_ENV_EXP_MODE_EN to honour the exponential mode bits.
module spu_adsr_envelope
  import spu_env_pkg::*;
#(
  parameter int unsigned LVL_W    = spu_env_pkg::LVL_W,
  parameter int unsigned ADR_W    = spu_env_pkg::ADR_W,
  parameter int unsigned DAT_W    = spu_env_pkg::DAT_W,
  parameter int unsigned STEP_LIN = spu_env_pkg::STEP_LIN
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             tick,
  input  logic             key_on,
  input  logic             key_off,
  input  logic             atk_exp,
  input  logic [6:0]       atk_rate,
  input  logic [3:0]       dec_shift,
  input  logic [3:0]       sus_level,
  input  logic             sus_exp,
  input  logic             sus_dec,
  input  logic [6:0]       sus_rate,
  input  logic             rel_exp,
  input  logic [4:0]       rel_shift,
  output logic [ADR_W-1:0] rom_adrs,
  output logic             rom_read,
  input  logic [DAT_W-1:0] rom_dout,
  output logic [LVL_W-1:0] env_level,
  output logic [2:0]       env_phase,
  output logic             busy
);

  seq_state_t       seq_q, seq_d;
  env_phase_t       phase_q, eff_phase;
  logic [LVL_W-1:0] level_q, step_level;
  logic [DAT_W:0]   acc_q;
  logic [DAT_W+1:0] sum;
  logic [6:0]       rate_idx;
  logic [2:0]       step_phase;
  logic             start, do_acc, carry;

  // key_off takes effect in the same cycle so an in-flight ACC steps as release
  assign eff_phase = (key_off && phase_q != PH_OFF) ? PH_RELEASE : phase_q;
  assign sum       = {1'b0, acc_q} + {2'b00, rom_dout};
  assign carry     = sum[DAT_W+1];

  spu_env_step #(.STEP(STEP_LIN)) u_step (
    .phase      (eff_phase),
    .apply      (carry),
    .level      (level_q),
    .atk_exp    (atk_exp),
    .atk_rate   (atk_rate),
    .dec_shift  (dec_shift),
    .sus_level  (sus_level),
    .sus_exp    (sus_exp),
    .sus_dec    (sus_dec),
    .sus_rate   (sus_rate),
    .rel_exp    (rel_exp),
    .rel_shift  (rel_shift),
    .rate_idx   (rate_idx),
    .level_next (step_level),
    .phase_next (step_phase)
  );

  always_comb begin
    seq_d  = seq_q;
    start  = 1'b0;
    do_acc = 1'b0;
    case (seq_q)
      SEQ_IDLE: if (tick && eff_phase != PH_OFF) begin
        seq_d = SEQ_READ;
        start = 1'b1;
      end
      SEQ_READ: seq_d = SEQ_ACC;
      SEQ_ACC: begin
        seq_d  = SEQ_IDLE;
        do_acc = 1'b1;
      end
      default: seq_d = SEQ_IDLE;
    endcase
    if (key_on) begin
      seq_d  = SEQ_IDLE;
      start  = 1'b0;
      do_acc = 1'b0;
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      seq_q    <= SEQ_IDLE;
      phase_q  <= PH_OFF;
      level_q  <= '0;
      acc_q    <= '0;
      rom_adrs <= '0;
      rom_read <= 1'b0;
      busy     <= 1'b0;
    end else begin
      seq_q    <= seq_d;
      rom_read <= start;
      busy     <= (seq_d != SEQ_IDLE);
      if (start) rom_adrs <= ADR_W'(rate_idx);
      if (key_on) begin
        phase_q <= PH_ATTACK;
        level_q <= '0;
        acc_q   <= '0;
      end else if (do_acc) begin
        acc_q   <= sum[DAT_W:0];
        level_q <= step_level;
        phase_q <= env_phase_t'(step_phase);
      end else if (key_off && phase_q != PH_OFF) begin
        phase_q <= PH_RELEASE;
      end
    end
  end

  assign env_level = level_q;
  assign env_phase = phase_q;

endmodule
